// File: rtl/fft_butterfly.sv
// +----------------------------------------------------------------------------+
// | fft_butterfly: 3-stage pipelined radix-2 DIT butterfly, X = A + W*B,       |
// | Y = A - W*B, with a valid/ready handshake and a combinational twiddle ROM. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fft_butterfly #(
  parameter int ROUND = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic signed [7:0] i_a_real,
  input  logic signed [7:0] i_a_imag,
  input  logic signed [7:0] i_b_real,
  input  logic signed [7:0] i_b_imag,
  input  logic        [2:0] i_tw_sel,
  output logic        [2:0] o_tw_sel,
  input  logic signed [7:0] i_twiddle_real,
  input  logic signed [7:0] i_twiddle_imag,
  output logic              o_valid,
  input  logic              i_ready,
  output logic signed [9:0] o_x_real,
  output logic signed [9:0] o_x_imag,
  output logic signed [9:0] o_y_real,
  output logic signed [9:0] o_y_imag
);

  localparam logic signed [16:0] RND_BIAS = (ROUND != 0) ? 17'sd64 : 17'sd0;

  logic en;
  logic accept;

  // Stage 1: captured operands
  logic              s1_valid;
  logic signed [7:0] s1_ar, s1_ai, s1_br, s1_bi, s1_wr, s1_wi;

  // Stage 2: partial products
  logic               s2_valid;
  logic signed [7:0]  s2_ar, s2_ai;
  logic signed [15:0] s2_rr, s2_ii, s2_ri, s2_ir;

  // Stage 3 combinational terms
  logic signed [16:0] pr_biased, pi_biased;
  logic signed [9:0]  s_real, s_imag;
  logic signed [9:0]  a_real_ext, a_imag_ext;
  logic               unused_lsbs;

  assign en       = !o_valid || i_ready;
  assign o_ready  = en;
  assign accept   = i_valid && en;
  assign o_tw_sel = i_tw_sel;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
    end else if (en) begin
      s1_valid <= accept;
      if (accept) begin
        s1_ar <= i_a_real;
        s1_ai <= i_a_imag;
        s1_br <= i_b_real;
        s1_bi <= i_b_imag;
        s1_wr <= i_twiddle_real;
        s1_wi <= i_twiddle_imag;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_valid <= 1'b0;
    end else if (en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_ar <= s1_ar;
        s2_ai <= s1_ai;
        s2_rr <= 16'(s1_br) * 16'(s1_wr);
        s2_ii <= 16'(s1_bi) * 16'(s1_wi);
        s2_ri <= 16'(s1_br) * 16'(s1_wi);
        s2_ir <= 16'(s1_bi) * 16'(s1_wr);
      end
    end
  end

  // Full-precision sums; bits [16:7] are exactly the arithmetic shift by 7.
  always_comb begin
    pr_biased  = 17'(s2_rr) - 17'(s2_ii) + RND_BIAS;
    pi_biased  = 17'(s2_ri) + 17'(s2_ir) + RND_BIAS;
    s_real     = pr_biased[16:7];
    s_imag     = pi_biased[16:7];
    a_real_ext = 10'(s2_ar);
    a_imag_ext = 10'(s2_ai);
  end

  assign unused_lsbs = ^{pr_biased[6:0], pi_biased[6:0]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid  <= 1'b0;
      o_x_real <= '0;
      o_x_imag <= '0;
      o_y_real <= '0;
      o_y_imag <= '0;
    end else if (en) begin
      o_valid <= s2_valid;
      if (s2_valid) begin
        o_x_real <= a_real_ext + s_real;
        o_x_imag <= a_imag_ext + s_imag;
        o_y_real <= a_real_ext - s_real;
        o_y_imag <= a_imag_ext - s_imag;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fft_butterfly.sv
// Scoreboard bench for fft_butterfly: directed vectors, decoupled driver and monitor.
`default_nettype none

module tb_fft_butterfly;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_valid;
  logic              o_ready;
  logic signed [7:0] a_re, a_im, b_re, b_im;
  logic        [2:0] tw_sel_in, tw_sel_out;
  logic signed [7:0] tw_re, tw_im;
  logic              o_valid;
  logic              i_ready;
  logic signed [9:0] x_re, x_im, y_re, y_im;

  always #5 clk = ~clk;

  fft_butterfly #(.ROUND(1)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_a_real       (a_re),
    .i_a_imag       (a_im),
    .i_b_real       (b_re),
    .i_b_imag       (b_im),
    .i_tw_sel       (tw_sel_in),
    .o_tw_sel       (tw_sel_out),
    .i_twiddle_real (tw_re),
    .i_twiddle_imag (tw_im),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_x_real       (x_re),
    .o_x_imag       (x_im),
    .o_y_real       (y_re),
    .o_y_imag       (y_im)
  );

  // Twiddle ROM: W16^k in Q1.7
  always_comb begin
    tw_re = 8'sd127;
    tw_im = 8'sd0;
    case (tw_sel_out)
      3'd0: begin tw_re =  8'sd127; tw_im =  8'sd0;   end
      3'd1: begin tw_re =  8'sd118; tw_im = -8'sd49;  end
      3'd2: begin tw_re =  8'sd91;  tw_im = -8'sd91;  end
      3'd3: begin tw_re =  8'sd49;  tw_im = -8'sd118; end
      3'd4: begin tw_re =  8'sd0;   tw_im = -8'sd128; end
      3'd5: begin tw_re = -8'sd49;  tw_im = -8'sd118; end
      3'd6: begin tw_re = -8'sd91;  tw_im = -8'sd91;  end
      3'd7: begin tw_re = -8'sd118; tw_im = -8'sd49;  end
      default: ;
    endcase
  end

  typedef struct {
    int k, ar, ai, br, bi, xr, xi, yr, yi;
  } vec_t;

  typedef struct {
    int xr, xi, yr, yi;
    int acc;
    bit lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t tv[9];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rcv = 0;
  int   stall_cycles = 0;
  bit   bp_arm = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: pops on transfer, checks held contents while stalled.
  always @(negedge clk) begin
    if (!rst && o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: actual o_valid=1 required o_valid=0 (nothing pending)");
      end else if (i_ready) begin
        mon_e = sb.pop_front();
        rcv++;
        check("x_real", int'(x_re), mon_e.xr);
        check("x_imag", int'(x_im), mon_e.xi);
        check("y_real", int'(y_re), mon_e.yr);
        check("y_imag", int'(y_im), mon_e.yi);
        if (mon_e.lat) check("latency", cyc - mon_e.acc, 3);
      end else begin
        mon_e = sb[0];
        stall_cycles++;
        check("stall_o_ready", int'(o_ready), 0);
        check("hold_x_real", int'(x_re), mon_e.xr);
        check("hold_y_imag", int'(y_im), mon_e.yi);
      end
    end
  end

  // Backpressure generator: 4 stalled cycles after the first result of the stream.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_arm && o_valid) begin
        i_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        i_ready = 1'b1;
        bp_arm = 1'b0;
      end
    end
  end

  // Call at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic send(input vec_t v, input bit lat);
    exp_t e;
    bit   done;
    done      = 1'b0;
    i_valid   = 1'b1;
    a_re      = v.ar[7:0];
    a_im      = v.ai[7:0];
    b_re      = v.br[7:0];
    b_im      = v.bi[7:0];
    tw_sel_in = v.k[2:0];
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (o_ready) begin
        check("tw_sel", int'(tw_sel_out), v.k);
        e.xr  = v.xr;
        e.xi  = v.xi;
        e.yr  = v.yr;
        e.yi  = v.yi;
        e.acc = cyc;
        e.lat = lat;
        @(posedge clk);
        sb.push_back(e);
        #1;
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: actual o_ready=0 for 100 cycles required=1");
    end
  endtask

  task automatic drain(input int bound);
    for (int n = 0; n < bound && sb.size() != 0; n++) @(posedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: actual pending=%0d required=0", sb.size());
      sb.delete();
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=simulation still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rcv0;
    //            k    ar    ai    br    bi    xr    xi    yr    yi
    tv[0] = '{0,   10,    0,   20,    0,   30,    0,  -10,    0};
    tv[1] = '{4,    0,    0,   64,    0,    0,  -64,    0,   64};
    tv[2] = '{4, -128, -128, -128, -128, -256,    0,    0, -256};
    tv[3] = '{0,    1,    2,   64,  -64,   65,  -61,  -63,   65};
    tv[4] = '{4,    5,   -5,   10,   20,   25,  -15,  -15,    5};
    tv[5] = '{2,    0,    0,  100,    0,   71,  -71,  -71,   71};
    tv[6] = '{0, -100,   50, -128,  127, -227,  176,   27,  -76};
    tv[7] = '{6,    3,    4,    0,   10,   10,   -3,   -4,   11};
    tv[8] = '{4,  127,  127,  127, -128,   -1,    0,  255,  254};

    // Reset held for two edges with a valid pair presented
    rst = 1'b1;
    i_valid = 1'b1;
    i_ready = 1'b1;
    a_re = 8'sd10; a_im = 8'sd0; b_re = 8'sd20; b_im = 8'sd0; tw_sel_in = 3'd0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_o_valid", int'(o_valid), 0);
      check("rst_o_ready", int'(o_ready), 1);
      check("rst_x_real", int'(x_re), 0);
      check("rst_x_imag", int'(x_im), 0);
      check("rst_y_real", int'(y_re), 0);
      check("rst_y_imag", int'(y_im), 0);
    end
    rst = 1'b0;
    i_valid = 1'b0;
    @(posedge clk);
    #1;

    // Single-pair vectors, first one with latency check
    send(tv[0], 1'b1);
    send(tv[1], 1'b0);
    send(tv[2], 1'b0);
    i_valid = 1'b0;
    drain(50);

    // Back-to-back stream of 6 with a 4-cycle stall
    rcv0 = rcv;
    stall_cycles = 0;
    bp_arm = 1'b1;
    for (int i = 3; i < 9; i++) send(tv[i], 1'b0);
    i_valid = 1'b0;
    drain(100);
    check("stream_delivered", rcv - rcv0, 6);
    check("stall_cycles", stall_cycles, 4);

    // Reset with two pairs in flight
    rcv0 = rcv;
    send(tv[3], 1'b0);
    send(tv[4], 1'b0);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_valid = 1'b0;
    @(negedge clk);
    check("midrst_o_valid", int'(o_valid), 0);
    repeat (10) @(posedge clk);
    check("midrst_no_output", rcv - rcv0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fft_butterfly.md
FFT_BUTTERFLY -- requirements
Module: fft_butterfly

Interface
REQ-001 Parameter: ROUND, 1, rounding mode for the twiddle product (1 = add 64 before the arithmetic shift right by 7; 0 = truncate).
REQ-002 Port: i_clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: i_rst  input  1  synchronous, active-high reset.
REQ-004 Port: i_valid  input  1  upstream sample pair valid.
REQ-005 Port: o_ready  output  1  block can accept a pair this cycle.
REQ-006 Port: i_a_real, i_a_imag  input  8 each  signed top-leg sample A.
REQ-007 Port: i_b_real, i_b_imag  input  8 each  signed bottom-leg sample B.
REQ-008 Port: i_tw_sel  input  3  twiddle index k (W16^k, k = 0..7).
REQ-009 Port: o_tw_sel  output  3  twiddle index to the twiddle ROM selector.
REQ-010 Port: i_twiddle_real, i_twiddle_imag  input  8 each  signed Q1.7 twiddle returned combinationally by the ROM.
REQ-011 Port: o_valid  output  1  result valid.
REQ-012 Port: i_ready  input  1  downstream can accept a result.
REQ-013 Port: o_x_real, o_x_imag, o_y_real, o_y_imag  output  10 each  signed results X = A + W·B and Y = A − W·B.

Function
REQ-014 o_tw_sel shall equal i_tw_sel combinationally; the twiddle inputs shall be sampled in the same cycle the pair is accepted.
REQ-015 Accept: i_valid && o_ready at a rising edge.
REQ-016 Pipeline enable en = !o_valid || i_ready; o_ready shall equal en; all three stages advance only when en = 1.
REQ-017 Stage 1 shall register A, B, W and a valid bit on accept; when en = 1 and there is no accept, the stage-1 valid bit shall load 0.
REQ-018 Stage 2 shall register the four 16-bit signed products br·wr, bi·wi, br·wi and bi·wr.
REQ-019 Stage 3 real term: pr = br·wr − bi·wi; imag term: pi = br·wi + bi·wr; both 17-bit signed, no intermediate truncation.
REQ-020 Stage 3 scaling: s = (p + (ROUND ? 64 : 0)) >>> 7, arithmetic shift, 10-bit signed result.
REQ-021 Stage 3 outputs: X = sext(A) + s and Y = sext(A) − s, 10-bit signed; no saturation is required because the range is provably within ±400.
REQ-022 Latency: o_valid shall rise exactly 3 enabled cycles after accept; with i_ready held at 1, throughput shall be 1 pair per cycle.
REQ-023 Backpressure: while o_valid && !i_ready, all outputs and all stage contents shall hold, o_ready shall be 0, and no data shall be lost or duplicated.
REQ-024 Results shall leave the block in acceptance order.
REQ-025 Bubbles (cycles with no accept) shall propagate as valid = 0 and shall never produce o_valid.
REQ-026 When a pair is accepted in the same cycle a result is consumed, both events shall complete with no stall.

Reset
REQ-027 While i_rst = 1 at a clock edge, all stage valid bits and o_valid shall clear to 0, and o_x_*/o_y_* shall clear to 0.
REQ-028 During reset o_ready shall evaluate to 1 (follows REQ-016).
REQ-029 Reset asserted mid-operation shall discard all in-flight pairs; no o_valid shall appear for them after reset releases.
REQ-030 Inputs presented in a reset cycle shall not be accepted.
REQ-031 The first accept may occur in the first cycle after i_rst deasserts.

Verification
REQ-032 Reset: i_rst = 1 for 2 cycles with i_valid = 1 -> o_valid = 0, all outputs 0, o_ready = 1, and no later o_valid.
REQ-033 k = 0 (W = 127 + j0), A = (10, 0), B = (20, 0), ROUND = 1, i_ready = 1 -> X = (30, 0), Y = (−10, 0), o_valid exactly 3 cycles after accept; o_tw_sel = 0 during accept.
REQ-034 k = 4 (W = 0 − j128), A = (0, 0), B = (64, 0) -> X = (0, −64), Y = (0, 64).
REQ-035 Extreme: k = 4, A = (−128, −128), B = (−128, −128) -> X = (−256, 0), Y = (0, −256); no wrap.
REQ-036 Backpressure: stream 6 pairs back-to-back with i_ready = 0 for 4 cycles after the first o_valid -> outputs held, o_ready = 0 while stalled, all 6 results delivered in order with none lost or duplicated.
REQ-037 Reset mid-stream: 2 pairs in flight, then a 1-cycle i_rst -> o_valid = 0 on the next cycle, and neither pair ever emerges.
